// File: rtl/fmap_reader_1.sv
// Feature-map frame reader.
// Streams NUM_WORDS words out of buffer port A (2-cycle read latency) into a
// small output FIFO. Reads are credit-gated so the FIFO can never overflow.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef POOL_ADDR_WIDTH
`define POOL_ADDR_WIDTH 4
`endif

module fmap_reader_1 #(
  parameter int DATA_WIDTH      = `DATA_WIDTH,
  parameter int POOL_ADDR_WIDTH = `POOL_ADDR_WIDTH,
  parameter int NUM_WORDS       = 2**POOL_ADDR_WIDTH,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      q_a,
  output logic [POOL_ADDR_WIDTH-1:0] address_a_t,
  output logic                       rden_a,
  output logic                       wren_a,
  output logic                       rden_b,
  output logic                       wren_b,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int AW     = POOL_ADDR_WIDTH;
  localparam int RD_LAT = 2;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int OW     = CW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                state_q;
  logic [AW-1:0]         rd_addr_q;    // next address to issue
  logic [AW-1:0]         last_addr_q;  // last issued address, shown when idle
  logic [RD_LAT:1]       vld_pipe_q;   // in-flight read tracker
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [OW-1:0]         occ;
  logic                  issue, push, pop, fifo_empty;

  // Occupancy counts words already buffered plus reads still in the RAM pipe;
  // a read is only issued when there is guaranteed room for its data.
  assign fifo_empty = (count_q == '0);
  assign occ        = OW'(count_q) + OW'(vld_pipe_q[1]) + OW'(vld_pipe_q[2]);
  assign issue      = (state_q == READ) && (occ < OW'(FIFO_DEPTH));
  assign push       = vld_pipe_q[RD_LAT];
  assign pop        = !fifo_empty && data_ready;
  assign count_d    = count_q + CW'(push) - CW'(pop);

  assign rden_a      = issue;
  assign address_a_t = issue ? rd_addr_q : last_addr_q;
  assign wren_a      = 1'b0;
  assign rden_b      = 1'b0;
  assign wren_b      = 1'b0;
  assign data_valid  = !fifo_empty;
  assign data_out    = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  // Frame control: start only honoured in IDLE, address never wraps in a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= READ;
          rd_addr_q <= '0;
        end
        READ: if (issue) begin
          last_addr_q <= rd_addr_q;
          if (rd_addr_q == LAST_ADDR) state_q <= DRAIN;
          else rd_addr_q <= rd_addr_q + 1'b1;
        end
        // Leave once nothing is in flight and this cycle empties the FIFO.
        DRAIN: if (vld_pipe_q == '0 && count_d == '0) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-latency shift register; reset drops any reads still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[RD_LAT-1:1], issue};
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= q_a;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // The credit rule must keep pushes away from a full FIFO.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && count_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fmap_reader_1.sv
// Bench for fmap_reader_1: a NUM_WORDS=8 and a NUM_WORDS=1 instance, each fed
// by a 2-cycle-latency RAM model; frames are scored against the word list.
module tb_fmap_reader_1;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start8 = 1'b0, start1 = 1'b0, data_ready = 1'b0;
  logic [DW-1:0] q8, q1, s8, s1, dout8, dout1;
  logic [AW-1:0] addr8, addr1;
  logic rden8, wrena8, rdenb8, wrenb8, dv8, busy8, done8;
  logic rden1, wrena1, rdenb1, wrenb1, dv1, busy1, done1;
  logic [DW-1:0] mem [16];

  int checks = 0, errors = 0;

  // collected by run8
  logic [DW-1:0] got[$];
  int nrd, popped, maxocc, ndone, donecyc, snap_nrd;
  bit addr_ok, tmo, snap_dv;
  logic [DW-1:0] snap_dout;

  always #5 clock = ~clock;

  fmap_reader_1 #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .NUM_WORDS(8), .FIFO_DEPTH(4)) u8 (
    .clock(clock), .reset(reset), .start(start8), .q_a(q8), .address_a_t(addr8),
    .rden_a(rden8), .wren_a(wrena8), .rden_b(rdenb8), .wren_b(wrenb8),
    .data_out(dout8), .data_valid(dv8), .data_ready(data_ready), .busy(busy8), .done(done8));

  fmap_reader_1 #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .NUM_WORDS(1), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .start(start1), .q_a(q1), .address_a_t(addr1),
    .rden_a(rden1), .wren_a(wrena1), .rden_b(rdenb1), .wren_b(wrenb1),
    .data_out(dout1), .data_valid(dv1), .data_ready(data_ready), .busy(busy1), .done(done1));

  // RAM model: data for a request in cycle n is on q in cycle n+2; junk otherwise.
  always @(posedge clock) begin
    s8 <= rden8 ? mem[addr8] : DW'($urandom);
    q8 <= s8;
    s1 <= rden1 ? mem[addr1] : DW'($urandom);
    q1 <= s1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return c[0];
      2:       return logic'($urandom_range(0, 1));
      3:       return (c >= 15);
      default: return 1'b1;
    endcase
  endfunction

  // Drive one frame on u8 (start in cycle 0, extra starts at sa/sb) and record
  // what comes out; the calling test judges the record.
  task automatic run8(input int mode, input int sa, input int sb);
    got.delete();
    nrd = 0; popped = 0; maxocc = 0; ndone = 0; donecyc = -1; snap_nrd = 0;
    addr_ok = 1'b1; tmo = 1'b1; snap_dv = 1'b0; snap_dout = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      start8     = (c == 0 || c == sa || c == sb);
      data_ready = rdy(mode, c);
      if (rden8) begin
        if (addr8 !== AW'(nrd)) addr_ok = 1'b0;
        nrd++;
      end
      if (nrd - popped > maxocc) maxocc = nrd - popped;
      if (dv8 && data_ready) begin got.push_back(dout8); popped++; end
      if (c == 14) begin snap_nrd = nrd; snap_dv = dv8; snap_dout = dout8; end
      if (done8 === 1'b1) begin ndone++; if (donecyc < 0) donecyc = c; end
      if (donecyc >= 0 && c == donecyc + 4) begin tmo = 1'b0; break; end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start8 = 1'b0; start1 = 1'b0; data_ready = 1'b0;
    repeat (3) tick();
    checks++; if ({rden8, dv8, busy8, done8, wrena8, rdenb8, wrenb8} !== 7'b0) begin errors++; $display("FAIL reset_ctl8 got %b exp 0", {rden8, dv8, busy8, done8, wrena8, rdenb8, wrenb8}); end
    checks++; if (addr8 !== '0) begin errors++; $display("FAIL reset_addr8 got %0d exp 0", addr8); end
    checks++; if (dout8 !== '0) begin errors++; $display("FAIL reset_dout8 got %0d exp 0", dout8); end
    checks++; if ({rden1, dv1, busy1, done1, wrena1, rdenb1, wrenb1} !== 7'b0) begin errors++; $display("FAIL reset_ctl1 got %b exp 0", {rden1, dv1, busy1, done1, wrena1, rdenb1, wrenb1}); end
    checks++; if (addr1 !== '0 || dout1 !== '0) begin errors++; $display("FAIL reset_data1 got %0d/%0d exp 0/0", addr1, dout1); end
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (busy8 !== 1'b0 || dv8 !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy %b dv %b exp 0 0", busy8, dv8); end
  endtask

  task automatic test_stream();
    logic er, ev, ed, eb;
    tick(); start8 = 1'b1; data_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin tick(); start8 = 1'b0; end
      er = (c >= 1 && c <= 8); ev = (c >= 4 && c <= 11);
      ed = (c == 12);          eb = (c >= 1 && c <= 12);
      checks++; if (rden8 !== er) begin errors++; $display("FAIL stream_rden c=%0d got %b exp %b", c, rden8, er); end
      if (er) begin checks++; if (addr8 !== AW'(c - 1)) begin errors++; $display("FAIL stream_addr c=%0d got %0d exp %0d", c, addr8, c - 1); end end
      checks++; if (dv8 !== ev) begin errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, dv8, ev); end
      if (ev) begin checks++; if (dout8 !== DW'(c + 12)) begin errors++; $display("FAIL stream_data c=%0d got %0d exp %0d", c, dout8, c + 12); end end
      checks++; if (done8 !== ed) begin errors++; $display("FAIL stream_done c=%0d got %b exp %b", c, done8, ed); end
      checks++; if (busy8 !== eb) begin errors++; $display("FAIL stream_busy c=%0d got %b exp %b", c, busy8, eb); end
      if (c == 5) begin checks++; if ({wrena8, rdenb8, wrenb8} !== 3'b0) begin errors++; $display("FAIL stream_wren got %b exp 000", {wrena8, rdenb8, wrenb8}); end end
    end
  endtask

  task automatic test_single();
    tick(); start1 = 1'b1; data_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin tick(); start1 = 1'b0; end
      checks++; if (rden1 !== (c == 1)) begin errors++; $display("FAIL single_rden c=%0d got %b", c, rden1); end
      if (c == 1) begin checks++; if (addr1 !== '0) begin errors++; $display("FAIL single_addr got %0d exp 0", addr1); end end
      checks++; if (dv1 !== (c == 4)) begin errors++; $display("FAIL single_valid c=%0d got %b", c, dv1); end
      if (c == 4) begin checks++; if (dout1 !== DW'(16)) begin errors++; $display("FAIL single_data got %0d exp 16", dout1); end end
      checks++; if (done1 !== (c == 5)) begin errors++; $display("FAIL single_done c=%0d got %b", c, done1); end
      checks++; if (busy1 !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL single_busy c=%0d got %b", c, busy1); end
    end
  endtask

  task automatic test_backpressure();
    run8(3, -1, -1);
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++; if (snap_nrd != 4) begin errors++; $display("FAIL bp_reads got %0d exp 4", snap_nrd); end
    checks++; if (snap_dv !== 1'b1 || snap_dout !== DW'(16)) begin errors++; $display("FAIL bp_hold got dv %b data %0d exp 1 16", snap_dv, snap_dout); end
    checks++; if (!addr_ok) begin errors++; $display("FAIL bp_addr got out-of-order exp 0..7"); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== DW'(16 + i)) begin errors++; $display("FAIL bp_word%0d got %0d exp %0d", i, got[i], 16 + i); end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", ndone); end
  endtask

  task automatic test_toggle();
    run8(1, -1, -1);
    checks++; if (tmo) begin errors++; $display("FAIL tog_timeout got no done exp done"); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL tog_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== DW'(16 + i)) begin errors++; $display("FAIL tog_word%0d got %0d exp %0d", i, got[i], 16 + i); end
    end
    checks++; if (maxocc > 4) begin errors++; $display("FAIL tog_occupancy got %0d exp <=4", maxocc); end
    checks++; if (ndone != 1 || !addr_ok || nrd != 8) begin errors++; $display("FAIL tog_frame got done %0d reads %0d addr_ok %0d exp 1 8 1", ndone, nrd, addr_ok); end
  endtask

  task automatic test_restart();
    run8(0, 3, 12);
    checks++; if (ndone != 1 || donecyc != 12) begin errors++; $display("FAIL restart_done got %0d at %0d exp 1 at 12", ndone, donecyc); end
    checks++; if (nrd != 8 || got.size() != 8) begin errors++; $display("FAIL restart_words got reads %0d words %0d exp 8 8", nrd, got.size()); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL restart_idle got busy %b done %b exp 0 0", busy8, done8); end
    end
  endtask

  task automatic test_reset_mid();
    tick(); start8 = 1'b1; data_ready = 1'b1;
    for (int c = 1; c < 6; c++) begin tick(); start8 = 1'b0; end
    tick(); reset = 1'b0; #1;
    checks++; if ({rden8, dv8, busy8, done8} !== 4'b0 || addr8 !== '0 || dout8 !== '0) begin errors++; $display("FAIL midrst_async got %b addr %0d data %0d exp 0", {rden8, dv8, busy8, done8}, addr8, dout8); end
    tick();
    checks++; if ({rden8, dv8, busy8, done8} !== 4'b0) begin errors++; $display("FAIL midrst_hold got %b exp 0", {rden8, dv8, busy8, done8}); end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({rden8, dv8, busy8, done8} !== 4'b0) begin errors++; $display("FAIL midrst_idle c=%0d got %b exp 0", c, {rden8, dv8, busy8, done8}); end
    end
    run8(0, -1, -1);
    checks++; if (!addr_ok || nrd != 8 || donecyc != 12) begin errors++; $display("FAIL midrst_frame got addr_ok %0d reads %0d done@%0d exp 1 8 12", addr_ok, nrd, donecyc); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL midrst_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== DW'(16 + i)) begin errors++; $display("FAIL midrst_word%0d got %0d exp %0d", i, got[i], 16 + i); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    for (int f = 0; f < 4; f++) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin mem[i] = DW'($urandom); exp_q.push_back(mem[i]); end
      run8(2, -1, -1);
      checks++; if (tmo || ndone != 1) begin errors++; $display("FAIL rand%0d_done got %0d timeout %0d exp 1 0", f, ndone, tmo); end
      checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h exp %h", f, i, got[i], exp_q[i]); end
      end
      checks++; if (maxocc > 4 || !addr_ok) begin errors++; $display("FAIL rand%0d_flow got occ %0d addr_ok %0d exp <=4 1", f, maxocc, addr_ok); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 16);
    test_reset();
    test_stream();
    test_single();
    test_backpressure();
    test_toggle();
    test_restart();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
